barrier_scheduler: RTL and testbench

BARRIER_SCHEDULER -- requirements
Module: barrier_scheduler

---
 rtl/barrier_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_barrier_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrier_scheduler.sv
// Barrier collision scheduler.
// Walks a small barrier table one entry at a time, drives each entry onto a
// shared combinational collision checker, and folds the checker's answers
// into per-frame tank collision codes and bullet hit flags/indices.
module barrier_scheduler #(
    parameter int NUM_BARRIERS = 8,
    parameter int IDX_W        = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [9:0]       cfg_x,
    input  logic [9:0]       cfg_y,
    input  logic [9:0]       cfg_hh,
    input  logic [9:0]       cfg_hl,
    input  logic             cfg_en,
    output logic [9:0]       chk_x,
    output logic [9:0]       chk_y,
    output logic [9:0]       chk_hh,
    output logic [9:0]       chk_hl,
    input  logic [3:0]       chk_p1,
    input  logic [3:0]       chk_p2,
    input  logic             chk_b1,
    input  logic             chk_b2,
    output logic [3:0]       p1_collision,
    output logic [3:0]       p2_collision,
    output logic             bullet1_hit,
    output logic             bullet2_hit,
    output logic [IDX_W-1:0] bullet1_idx,
    output logic [IDX_W-1:0] bullet2_idx,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SAMPLE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Barrier table
    logic [9:0] r_tx  [NUM_BARRIERS];
    logic [9:0] r_ty  [NUM_BARRIERS];
    logic [9:0] r_thh [NUM_BARRIERS];
    logic [9:0] r_thl [NUM_BARRIERS];
    logic       r_ten [NUM_BARRIERS];

    // Scan state and accumulators
    logic [IDX_W-1:0] r_idx;
    logic             r_en_q;
    logic [3:0]       r_acc_p1;
    logic [3:0]       r_acc_p2;
    logic             r_acc_b1;
    logic             r_acc_b2;
    logic [IDX_W-1:0] r_acc_b1_idx;
    logic [IDX_W-1:0] r_acc_b2_idx;

    // Decoded control
    logic w_last;
    logic w_start;
    logic w_load;
    logic w_sample;
    logic w_final;
    logic w_ovr;

    // Accumulators including the current sample
    logic [3:0]       w_acc_p1;
    logic [3:0]       w_acc_p2;
    logic             w_acc_b1;
    logic             w_acc_b2;
    logic [IDX_W-1:0] w_acc_b1_idx;
    logic [IDX_W-1:0] w_acc_b2_idx;

    assign w_last = (r_idx == IDX_W'(NUM_BARRIERS - 1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_next = LOAD;
            LOAD:    w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded control strobes; a request outside IDLE is dropped
    always_comb begin
        w_start  = (r_state == IDLE) && frame_start;
        w_load   = (r_state == LOAD);
        w_sample = (r_state == SAMPLE);
        w_final  = w_sample && w_last;
        w_ovr    = frame_start && (r_state != IDLE);
    end

    // Fold this cycle's checker result into the running accumulators
    always_comb begin
        w_acc_p1     = r_acc_p1;
        w_acc_p2     = r_acc_p2;
        w_acc_b1     = r_acc_b1;
        w_acc_b2     = r_acc_b2;
        w_acc_b1_idx = r_acc_b1_idx;
        w_acc_b2_idx = r_acc_b2_idx;
        if (r_en_q) begin
            w_acc_p1 = r_acc_p1 | chk_p1;
            w_acc_p2 = r_acc_p2 | chk_p2;
            if (chk_b1) begin
                w_acc_b1 = 1'b1;
                if (!r_acc_b1) w_acc_b1_idx = r_idx;
            end
            if (chk_b2) begin
                w_acc_b2 = 1'b1;
                if (!r_acc_b2) w_acc_b2_idx = r_idx;
            end
        end
    end

    // Table write port; a LOAD on the same edge still reads the old entry
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_BARRIERS; i++) begin
                r_tx[i]  <= '0;
                r_ty[i]  <= '0;
                r_thh[i] <= '0;
                r_thl[i] <= '0;
                r_ten[i] <= 1'b0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_BARRIERS)) begin
            r_tx[cfg_idx]  <= cfg_x;
            r_ty[cfg_idx]  <= cfg_y;
            r_thh[cfg_idx] <= cfg_hh;
            r_thl[cfg_idx] <= cfg_hl;
            r_ten[cfg_idx] <= cfg_en;
        end
    end

    // Scan datapath: checker drive, accumulation and result publication
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_idx        <= '0;
            r_en_q       <= 1'b0;
            r_acc_p1     <= '0;
            r_acc_p2     <= '0;
            r_acc_b1     <= 1'b0;
            r_acc_b2     <= 1'b0;
            r_acc_b1_idx <= '0;
            r_acc_b2_idx <= '0;
            chk_x        <= '0;
            chk_y        <= '0;
            chk_hh       <= '0;
            chk_hl       <= '0;
            p1_collision <= '0;
            p2_collision <= '0;
            bullet1_hit  <= 1'b0;
            bullet2_hit  <= 1'b0;
            bullet1_idx  <= '0;
            bullet2_idx  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= w_ovr;
            if (w_start) begin
                r_idx        <= '0;
                r_acc_p1     <= '0;
                r_acc_p2     <= '0;
                r_acc_b1     <= 1'b0;
                r_acc_b2     <= 1'b0;
                r_acc_b1_idx <= '0;
                r_acc_b2_idx <= '0;
                busy         <= 1'b1;
            end
            if (w_load) begin
                chk_x  <= r_tx[r_idx];
                chk_y  <= r_ty[r_idx];
                chk_hh <= r_thh[r_idx];
                chk_hl <= r_thl[r_idx];
                r_en_q <= r_ten[r_idx];
            end
            if (w_sample) begin
                r_acc_p1     <= w_acc_p1;
                r_acc_p2     <= w_acc_p2;
                r_acc_b1     <= w_acc_b1;
                r_acc_b2     <= w_acc_b2;
                r_acc_b1_idx <= w_acc_b1_idx;
                r_acc_b2_idx <= w_acc_b2_idx;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
            if (w_final) begin
                p1_collision <= w_acc_p1;
                p2_collision <= w_acc_p2;
                bullet1_hit  <= w_acc_b1;
                bullet2_hit  <= w_acc_b2;
                bullet1_idx  <= w_acc_b1_idx;
                bullet2_idx  <= w_acc_b2_idx;
                done         <= 1'b1;
                busy         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_barrier_scheduler.sv
// Directed bench for barrier_scheduler with a table-driven checker model
// keyed on the barrier X coordinate the DUT drives.
module tb_barrier_scheduler;

    logic       Clk;
    logic       Reset;
    logic       frame_start;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [9:0] cfg_x, cfg_y, cfg_hh, cfg_hl;
    logic       cfg_en;
    logic [9:0] chk_x, chk_y, chk_hh, chk_hl;
    logic [3:0] chk_p1, chk_p2;
    logic       chk_b1, chk_b2;
    logic [3:0] p1_collision, p2_collision;
    logic       bullet1_hit, bullet2_hit;
    logic [2:0] bullet1_idx, bullet2_idx;
    logic       busy, done, overrun;

    int tests = 0;
    int fails = 0;

    // Checker model: response per table slot, matched on chk_x
    logic [9:0] xs  [8];
    logic [3:0] rp1 [8];
    logic [3:0] rp2 [8];
    logic       rb1 [8];
    logic       rb2 [8];

    barrier_scheduler #(.NUM_BARRIERS(8), .IDX_W(3)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_hh(cfg_hh), .cfg_hl(cfg_hl),
        .cfg_en(cfg_en),
        .chk_x(chk_x), .chk_y(chk_y), .chk_hh(chk_hh), .chk_hl(chk_hl),
        .chk_p1(chk_p1), .chk_p2(chk_p2), .chk_b1(chk_b1), .chk_b2(chk_b2),
        .p1_collision(p1_collision), .p2_collision(p2_collision),
        .bullet1_hit(bullet1_hit), .bullet2_hit(bullet2_hit),
        .bullet1_idx(bullet1_idx), .bullet2_idx(bullet2_idx),
        .busy(busy), .done(done), .overrun(overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        chk_p1 = '0;
        chk_p2 = '0;
        chk_b1 = 1'b0;
        chk_b2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (chk_x == xs[i]) begin
                chk_p1 = rp1[i];
                chk_p2 = rp2[i];
                chk_b1 = rb1[i];
                chk_b2 = rb2[i];
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [9:0] x, input logic en);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_x   = x;
        cfg_y   = 10'd240;
        cfg_hh  = 10'd20;
        cfg_hl  = 10'd40;
        cfg_en  = en;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Start a frame at edge 0, then run 40 edges with optional extra
    // requests and an optional write to entry 4 at a chosen edge.
    task automatic scan(input int fs_a, input int fs_b, input int cfg_at,
                        input logic [9:0] new_x, input int cap_at,
                        output int done_at, output int done_cnt,
                        output int ovr_cnt, output logic busy1,
                        output logic [9:0] capx);
        done_at  = -1;
        done_cnt = 0;
        ovr_cnt  = 0;
        capx     = '0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        busy1 = busy;
        for (int n = 1; n <= 40; n++) begin
            frame_start = (n == fs_a) || (n == fs_b);
            if (n == cfg_at) begin
                cfg_we  = 1'b1;
                cfg_idx = 3'd4;
                cfg_x   = new_x;
                cfg_en  = 1'b0;
            end
            tick();
            frame_start = 1'b0;
            cfg_we      = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (overrun) ovr_cnt++;
            if (n == cap_at) capx = chk_x;
        end
    endtask

    int         d_at, d_cnt, o_cnt;
    logic       b1;
    logic [9:0] cx;

    initial begin
        for (int i = 0; i < 8; i++) begin
            xs[i]  = 10'd1023;
            rp1[i] = '0;
            rp2[i] = '0;
            rb1[i] = 1'b0;
            rb2[i] = 1'b0;
        end
        Reset = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_x = '0; cfg_y = '0; cfg_hh = '0; cfg_hl = '0; cfg_en = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_p1", p1_collision, 0);
        chk("rst_chkx", chk_x, 0);

        // Single enabled barrier hit by tank 1
        cfg(3'd2, 10'd320, 1'b1); xs[2] = 10'd320; rp1[2] = 4'b0001;
        cfg(3'd7, 10'd700, 1'b0); xs[7] = 10'd700;
        scan(-1, -1, -1, '0, -1, d_at, d_cnt, o_cnt, b1, cx);
        chk("a_busy_start", b1, 1);
        chk("a_done_at", d_at, 16);
        chk("a_done_cnt", d_cnt, 1);
        chk("a_ovr", o_cnt, 0);
        chk("a_busy_end", busy, 0);
        chk("a_done_low", done, 0);
        chk("a_p1", p1_collision, 4'b0001);
        chk("a_p2", p2_collision, 0);
        chk("a_b1", bullet1_hit, 0);
        chk("a_b1_idx", bullet1_idx, 0);
        chk("a_chkx_hold", chk_x, 700);

        // Bullet hits on entries 1 and 5, multi-hot tank code
        cfg(3'd1, 10'd110, 1'b1); xs[1] = 10'd110; rb1[1] = 1'b1;
        cfg(3'd5, 10'd150, 1'b1); xs[5] = 10'd150; rb1[5] = 1'b1;
        rb2[5] = 1'b1; rp1[5] = 4'b0100;
        scan(-1, -1, -1, '0, -1, d_at, d_cnt, o_cnt, b1, cx);
        chk("b_done_at", d_at, 16);
        chk("b_p1_multi", p1_collision, 4'b0101);
        chk("b_b1", bullet1_hit, 1);
        chk("b_b1_idx", bullet1_idx, 1);
        chk("b_b2", bullet2_hit, 1);
        chk("b_b2_idx", bullet2_idx, 5);

        // Disabled entry reporting a collision is ignored
        cfg(3'd3, 10'd130, 1'b0); xs[3] = 10'd130; rp2[3] = 4'b1000;
        cfg(3'd6, 10'd160, 1'b1); xs[6] = 10'd160; rp2[6] = 4'b0010;
        scan(-1, -1, -1, '0, -1, d_at, d_cnt, o_cnt, b1, cx);
        chk("c_done_at", d_at, 16);
        chk("c_p2", p2_collision, 4'b0010);
        chk("c_p1", p1_collision, 4'b0101);

        // Requests mid-scan and on the final SAMPLE edge are dropped
        scan(5, 16, -1, '0, -1, d_at, d_cnt, o_cnt, b1, cx);
        chk("d_ovr_cnt", o_cnt, 2);
        chk("d_done_cnt", d_cnt, 1);
        chk("d_done_at", d_at, 16);
        chk("d_busy_end", busy, 0);

        // Config race on entry 4 at its LOAD edge, then next frame
        cfg(3'd4, 10'd140, 1'b0); xs[4] = 10'd140;
        scan(-1, -1, 9, 10'd444, 9, d_at, d_cnt, o_cnt, b1, cx);
        chk("f_old_x", cx, 140);
        scan(-1, -1, -1, '0, 9, d_at, d_cnt, o_cnt, b1, cx);
        chk("f_new_x", cx, 444);
        scan(-1, -1, 3, 10'd555, 9, d_at, d_cnt, o_cnt, b1, cx);
        chk("f_early_write", cx, 555);

        // Reset at edge 9 of a scan, with competing request and write
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int n = 1; n <= 8; n++) tick();
        Reset = 1'b1; frame_start = 1'b1;
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_x = 10'd320; cfg_en = 1'b1;
        tick();
        Reset = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
        chk("e_busy", busy, 0);
        chk("e_done", done, 0);
        chk("e_ovr", overrun, 0);
        chk("e_p1", p1_collision, 0);
        chk("e_p2", p2_collision, 0);
        chk("e_b1", bullet1_hit, 0);
        chk("e_b2_idx", bullet2_idx, 0);
        chk("e_chkx", chk_x, 0);
        d_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done) d_cnt++;
        end
        chk("e_no_done", d_cnt, 0);
        scan(-1, -1, -1, '0, -1, d_at, d_cnt, o_cnt, b1, cx);
        chk("e_fresh_done_at", d_at, 16);
        chk("e_fresh_p1", p1_collision, 0);
        chk("e_fresh_p2", p2_collision, 0);
        chk("e_fresh_b1", bullet1_hit, 0);
        chk("e_fresh_b2", bullet2_hit, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
